mem_ctrl: RTL and testbench

Sequencer and arbiter for the single byte-wide RAM/IO port. Serves two requesters: instruction fetch, which reads whole 64-byte cache blocks, and the load/store buffer, which reads or writes 1, 2 or 4 bytes. One transaction is in flight at a time. The block issues one byte address per cycle, assembles or splits words little-endian, stalls IO writes while the IO buffer is full, and cancels speculative loads on rollback.

---
 rtl/mem_ctrl.sv | 161 ++++++++++++++++
 tb/tb_mem_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbiter and byte sequencer for the shared byte-wide RAM/IO port.
// Serves 64-byte fetch reads and 1/2/4-byte load/store accesses, one at a time.
module mem_ctrl (
    input  logic         clk,
    input  logic         rst,
    input  logic         rdy,
    input  logic [7:0]   mem_din,
    output logic [7:0]   mem_dout,
    output logic [31:0]  mem_a,
    output logic         mem_wr,
    input  logic         io_buffer_full,
    input  logic         if_en,
    input  logic [31:0]  if_pc,
    output logic         if_done,
    output logic [511:0] if_data,
    input  logic         lsb_en,
    input  logic         lsb_wr,
    input  logic [31:0]  lsb_addr,
    input  logic [1:0]   lsb_len,
    input  logic [31:0]  lsb_wdata,
    output logic         lsb_done,
    output logic [31:0]  lsb_rdata,
    input  logic         rob_clear
);
    localparam logic [1:0] IDLE = 2'd0, IF_READ = 2'd1, LS_READ = 2'd2, LS_WRITE = 2'd3;
    logic [1:0]   state_q, state_d;
    logic [6:0]   cnt_q, cnt_d, len_q, len_d;
    logic [31:0]  base_q, base_d, wdata_q, wdata_d, mem_a_q, mem_a_d;
    logic         last_grant_q, last_grant_d, mem_wr_q, mem_wr_d;
    logic [7:0]   mem_dout_q, mem_dout_d;
    logic         if_done_q, if_done_d, lsb_done_q, lsb_done_d;
    logic [511:0] if_data_q, if_data_d;
    logic [31:0]  lsb_rdata_q, lsb_rdata_d;
    logic [6:0]   n_ls;
    logic [5:0]   idx;
    logic         free, gnt_ls, gnt_if;
    logic [31:0]  a_next, a_wr;
    // No grant while a done pulse is up: the requester is dropping en on that edge.
    assign free   = ~if_done_q & ~lsb_done_q;
    assign gnt_ls = free & lsb_en & ~rob_clear & (~if_en | ~last_grant_q);
    assign gnt_if = free & if_en & ~gnt_ls;
    assign n_ls   = lsb_len[1] ? 7'd4 : lsb_len[0] ? 7'd2 : 7'd1;
    assign idx    = 6'(cnt_q - 7'd1);
    assign a_next = base_q + 32'(cnt_q) + 32'd1;
    assign a_wr   = base_q + 32'(cnt_q);
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        len_d        = len_q;
        base_d       = base_q;
        wdata_d      = wdata_q;
        last_grant_d = last_grant_q;
        mem_a_d      = '0;
        mem_wr_d     = 1'b0;
        mem_dout_d   = mem_dout_q;
        if_done_d    = 1'b0;
        lsb_done_d   = 1'b0;
        if_data_d    = if_data_q;
        lsb_rdata_d  = lsb_rdata_q;
        case (state_q)
            IDLE: begin
                if (gnt_if) begin
                    state_d      = IF_READ;
                    last_grant_d = 1'b0;
                    cnt_d        = '0;
                    len_d        = 7'd64;
                    base_d       = if_pc;
                    mem_a_d      = if_pc;
                end else if (gnt_ls) begin
                    last_grant_d = 1'b1;
                    cnt_d        = '0;
                    len_d        = n_ls;
                    base_d       = lsb_addr;
                    wdata_d      = lsb_wdata;
                    if (!lsb_wr) begin
                        state_d     = LS_READ;
                        lsb_rdata_d = '0;
                        mem_a_d     = lsb_addr;
                    end else begin
                        state_d = LS_WRITE;
                        if (!(lsb_addr[17:16] == 2'b11 && io_buffer_full)) begin
                            mem_wr_d   = 1'b1;
                            mem_a_d    = lsb_addr;
                            mem_dout_d = lsb_wdata[7:0];
                            cnt_d      = 7'd1;
                        end
                    end
                end
            end
            IF_READ, LS_READ: begin
                if (state_q == LS_READ && rob_clear) begin
                    state_d     = IDLE;
                    lsb_rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                    if (cnt_q + 7'd1 < len_q) mem_a_d = a_next;
                    // Data returns one cycle after its address, so byte cnt-1 lands now.
                    if (cnt_q != 7'd0) begin
                        if (state_q == IF_READ) if_data_d[{idx, 3'b000} +: 8] = mem_din;
                        else lsb_rdata_d[{idx[1:0], 3'b000} +: 8] = mem_din;
                    end
                    if (cnt_q == len_q) begin
                        state_d    = IDLE;
                        if_done_d  = state_q == IF_READ;
                        lsb_done_d = state_q == LS_READ;
                    end
                end
            end
            LS_WRITE: begin
                if (cnt_q == len_q) begin
                    state_d    = IDLE;
                    lsb_done_d = 1'b1;
                end else if (!(a_wr[17:16] == 2'b11 && io_buffer_full)) begin
                    mem_wr_d   = 1'b1;
                    mem_a_d    = a_wr;
                    mem_dout_d = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                    cnt_d      = cnt_q + 7'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            len_q        <= '0;
            base_q       <= '0;
            wdata_q      <= '0;
            last_grant_q <= 1'b1;
            mem_a_q      <= '0;
            mem_wr_q     <= 1'b0;
            mem_dout_q   <= '0;
            if_done_q    <= 1'b0;
            lsb_done_q   <= 1'b0;
            if_data_q    <= '0;
            lsb_rdata_q  <= '0;
        end else if (rdy) begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            base_q       <= base_d;
            wdata_q      <= wdata_d;
            last_grant_q <= last_grant_d;
            mem_a_q      <= mem_a_d;
            mem_wr_q     <= mem_wr_d;
            mem_dout_q   <= mem_dout_d;
            if_done_q    <= if_done_d;
            lsb_done_q   <= lsb_done_d;
            if_data_q    <= if_data_d;
            lsb_rdata_q  <= lsb_rdata_d;
        end
    end
    assign mem_a     = mem_a_q;
    assign mem_wr    = mem_wr_q;
    assign mem_dout  = mem_dout_q;
    assign if_done   = if_done_q;
    assign lsb_done  = lsb_done_q;
    assign if_data   = if_data_q;
    assign lsb_rdata = lsb_rdata_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: scoreboard bench for mem_ctrl with a byte-array RAM reference model.
module tb_mem_ctrl;
    logic clk = 0, rst = 1, rdy = 1;
    logic [7:0] mem_din, mem_dout;
    logic [31:0] mem_a;
    logic mem_wr, io_buffer_full = 0;
    logic if_en = 0, if_done, lsb_en = 0, lsb_wr = 0, lsb_done, rob_clear = 0;
    logic [31:0] if_pc = 0, lsb_addr = 0, lsb_wdata = 0, lsb_rdata;
    logic [1:0] lsb_len = 0;
    logic [511:0] if_data;

    mem_ctrl dut (.clk(clk), .rst(rst), .rdy(rdy), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full), .if_en(if_en),
        .if_pc(if_pc), .if_done(if_done), .if_data(if_data), .lsb_en(lsb_en), .lsb_wr(lsb_wr),
        .lsb_addr(lsb_addr), .lsb_len(lsb_len), .lsb_wdata(lsb_wdata), .lsb_done(lsb_done),
        .lsb_rdata(lsb_rdata), .rob_clear(rob_clear));

    always #5 clk = ~clk;

    typedef struct { logic [511:0] data; int cyc; bit chk; } exp_t;
    exp_t ifq[$], lsq[$], m_e;
    logic [39:0] wq[$], m_w;
    logic [7:0] pre [logic [31:0]];
    logic [7:0] ram [logic [31:0]];
    logic [7:0] ref_mem [logic [31:0]];
    int cyc = 0, passed = 0, total = 0, n_if = 0, n_ls = 0, n_if_exp = 0, n_ls_exp = 0;
    bit rnd_io;

    function automatic logic [7:0] init_b(input logic [31:0] a);
        if (pre.exists(a)) return pre[a];
        return a[7:0] ^ a[23:16] ^ a[31:24];
    endfunction
    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : init_b(a);
    endfunction
    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_b(a);
    endfunction

    // RAM stalls with rdy, one cycle read latency
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rdy) begin
            if (mem_wr) ram[mem_a] = mem_dout;
            mem_din <= ram_rd(mem_a);
        end
    end

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic if_req(input logic [31:0] pc, input int dly, input int off);
        exp_t e;
        int c;
        bit got = 0;
        repeat (dly + 1) @(posedge clk);
        #1 if_pc = pc; if_en = 1; c = cyc;
        for (int k = 0; k < 64; k++) e.data[8*k +: 8] = ref_rd(pc + k);
        e.cyc = off < 0 ? -1 : c + off;
        e.chk = 1;
        ifq.push_back(e); n_if_exp++;
        for (int i = 0; i < 400 && !got; i++) begin @(negedge clk); got = if_done && rdy; end
        if (!got) begin total++; $display("FAIL if_timeout: no if_done in 400 cycles for pc %h", pc); end
        @(posedge clk); #1 if_en = 0;
    endtask

    // off < -1 selects the nominal latency for an uncontended access
    task automatic lsb_req(input bit wr, input logic [31:0] a, input logic [1:0] len,
                           input logic [31:0] wd, input int dly, input int off);
        exp_t e;
        int c, n;
        bit got = 0, io = 0;
        logic [31:0] t;
        n = len == 2 ? 4 : len == 1 ? 2 : 1;
        repeat (dly + 1) @(posedge clk);
        #1 lsb_en = 1; lsb_wr = wr; lsb_addr = a; lsb_len = len; lsb_wdata = wd; c = cyc;
        e.data = '0;
        for (int k = 0; k < n; k++) begin
            t = a + k;
            if (t[17:16] == 2'b11) io = 1;
            if (wr) begin wq.push_back({t, wd[8*k +: 8]}); ref_mem[t] = wd[8*k +: 8]; end
            else e.data[8*k +: 8] = ref_rd(t);
        end
        if (off < -1) off = wr ? (io ? -1 : n + 1) : n + 2;
        e.cyc = off < 0 ? -1 : c + off;
        e.chk = !wr;
        lsq.push_back(e); n_ls_exp++;
        for (int i = 0; i < 400 && !got; i++) begin @(negedge clk); got = lsb_done && rdy; end
        if (!got) begin total++; $display("FAIL lsb_timeout: no lsb_done in 400 cycles for addr %h", a); end
        @(posedge clk); #1 lsb_en = 0;
    endtask

    task automatic chk_reset(input string tag);
        check({tag, "_if_data"}, if_data, '0);
        check({tag, "_ctl"}, {lsb_rdata, mem_a, mem_dout, mem_wr, if_done, lsb_done}, '0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        pre[32'h100] = 8'h11; pre[32'h101] = 8'h22; pre[32'h102] = 8'h33; pre[32'h103] = 8'h44;
        fork
            forever begin
                @(negedge clk);
                if (!rst && rdy) begin
                    if (mem_wr) begin
                        check("wr_expected", 512'(wq.size() != 0), 1);
                        if (wq.size() != 0) begin m_w = wq.pop_front(); check("wr_addr_data", {mem_a, mem_dout}, m_w); end
                    end
                    if (if_done) begin
                        n_if++;
                        check("if_expected", 512'(ifq.size() != 0), 1);
                        if (ifq.size() != 0) begin
                            m_e = ifq.pop_front();
                            check("if_data", if_data, m_e.data);
                            if (m_e.cyc >= 0) check("if_cycle", cyc, m_e.cyc);
                        end
                    end
                    if (lsb_done) begin
                        n_ls++;
                        check("lsb_expected", 512'(lsq.size() != 0), 1);
                        if (lsq.size() != 0) begin
                            m_e = lsq.pop_front();
                            if (m_e.chk) check("lsb_rdata", lsb_rdata, m_e.data[31:0]);
                            if (m_e.cyc >= 0) check("lsb_cycle", cyc, m_e.cyc);
                        end
                    end
                end
            end
        join_none
        repeat (3) @(posedge clk);
        #1 rst = 0;
        chk_reset("reset");
        // simultaneous after reset: fetch first, then load
        fork
            if_req(32'h1040, 0, 66);
            lsb_req(0, 32'h100, 2, 0, 0, 73);
        join
        lsb_req(0, 32'h101, 0, 0, 0, -2);
        if_req(32'h2000, 0, 66);
        // last grant was fetch, so the load wins this time
        fork
            if_req(32'h3FC0, 0, 73);
            lsb_req(0, 32'h104, 2, 0, 0, 6);
        join
        fork
            lsb_req(1, 32'h30004, 1, 32'h0000BEEF, 0, 6);
            begin @(posedge clk); #1 io_buffer_full = 1; repeat (3) @(posedge clk); #1 io_buffer_full = 0; end
        join
        lsb_req(0, 32'h30004, 1, 0, 0, -2);
        // load aborted by rollback in its 3rd cycle; fetch pending behind it
        fork
            begin
                @(posedge clk);
                #1 lsb_en = 1; lsb_wr = 0; lsb_addr = 32'h200; lsb_len = 2;
                repeat (3) @(posedge clk);
                #1 rob_clear = 1;
                @(posedge clk);
                #1 rob_clear = 0; lsb_en = 0;
            end
            if_req(32'h4000, 2, 68);
        join
        fork
            lsb_req(1, 32'h500, 2, 32'hCAFEF00D, 0, 5);
            begin repeat (3) @(posedge clk); #1 rob_clear = 1; @(posedge clk); #1 rob_clear = 0; end
        join
        lsb_req(0, 32'h500, 2, 0, 0, -2);
        @(posedge clk);
        #1 if_en = 1; if_pc = 32'h5000;
        repeat (20) @(posedge clk);
        #1 rst = 1; if_en = 0;
        @(posedge clk);
        #1 rst = 0;
        chk_reset("midreset");
        repeat (3) @(posedge clk);
        fork
            if_req(32'h1040, 0, 71);
            begin repeat (31) @(posedge clk); #1 rdy = 0; repeat (5) @(posedge clk); #1 rdy = 1; end
        join
        rnd_io = 1;
        fork
            begin
                while (rnd_io) begin @(posedge clk); #1 io_buffer_full = $urandom_range(0, 2) == 0; end
                io_buffer_full = 0;
            end
            begin
                logic [31:0] a;
                for (int t = 0; t < 50; t++) begin
                    a = $urandom_range(0, 1) != 0 ? $urandom : 32'($urandom_range(0, 63));
                    if ($urandom_range(0, 3) == 0) a[17:16] = 2'b11;
                    if ($urandom_range(0, 4) == 0) if_req(a & 32'hFFFF_FFC0, $urandom_range(0, 2), 66);
                    else lsb_req($urandom_range(0, 1) != 0, a, 2'($urandom_range(0, 2)), $urandom, $urandom_range(0, 2), -2);
                end
                rnd_io = 0;
            end
        join
        repeat (5) @(posedge clk);
        check("if_done_count", n_if, n_if_exp);
        check("lsb_done_count", n_ls, n_ls_exp);
        check("writes_left", wq.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
